// File: rtl/fp_add_sched_if.sv
// Requester-facing bundle of fp_add_sched: two request ports, a shared
// response channel, sticky status and completed-operation counters.
interface fp_add_sched_if #(
  parameter int CNT_W = 16
);
  // Valid/ready: a transfer happens on the rising edge where valid and ready are
  // both 1; valid and its payload stay stable until then, and ready may depend
  // combinationally on valid but valid never waits on ready.
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req_a0;
  logic [31:0]      req_b0;
  logic [31:0]      req_a1;
  logic [31:0]      req_b1;
  logic [2:0]       req_rmode0;
  logic [2:0]       req_rmode1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_ovf;
  logic             rsp_unf;
  logic             rsp_illegal;
  logic [1:0]       sticky_ovf;
  logic [1:0]       sticky_unf;
  logic [1:0]       sticky_clr;
  logic [CNT_W-1:0] op_cnt0;
  logic [CNT_W-1:0] op_cnt1;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_rmode0, req_rmode1,
    output rsp_ready, sticky_clr,
    input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_unf, rsp_illegal,
    input  sticky_ovf, sticky_unf, op_cnt0, op_cnt1
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_rmode0, req_rmode1,
    input  rsp_ready, sticky_clr,
    output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_unf, rsp_illegal,
    output sticky_ovf, sticky_unf, op_cnt0, op_cnt1
  );
endinterface

// File: rtl/fp_add_sched.sv
// Shares one combinational fp_adder between two requesters: round-robin grant,
// registered operands, one-cycle result capture and a held response.
module fp_add_sched #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  fp_add_sched_if.slave      req,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  output logic [2:0]         add_rmode,
  input  logic [31:0]        add_result,
  input  logic               add_overflow,
  input  logic               add_underflow,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t           state;
  logic             last_grant;
  logic             op_g;
  logic             op_illegal;
  logic             grant;
  logic [1:0]       req_ready_c;
  logic             req_fire;
  logic             rsp_fire;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [2:0]       sel_rm;
  logic [1:0]       set_ovf;
  logic [1:0]       set_unf;
  logic [1:0]       rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic             rsp_ovf_q;
  logic             rsp_unf_q;
  logic             rsp_illegal_q;
  logic [1:0]       sticky_ovf_q;
  logic [1:0]       sticky_unf_q;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant = 1'b0;
    case (req.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    req_ready_c = 2'b00;
    if (state == IDLE) req_ready_c[grant] = req.req_valid[grant];
  end

  assign req_fire = |req_ready_c;
  assign rsp_fire = (state == RESP) && req.rsp_ready[op_g];
  assign sel_a    = grant ? req.req_a1 : req.req_a0;
  assign sel_b    = grant ? req.req_b1 : req.req_b0;
  assign sel_rm   = grant ? req.req_rmode1 : req.req_rmode0;

  always_comb begin
    set_ovf = 2'b00;
    set_unf = 2'b00;
    if (rsp_fire) begin
      set_ovf[op_g] = rsp_ovf_q;
      set_unf[op_g] = rsp_unf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      op_g          <= 1'b0;
      op_illegal    <= 1'b0;
      add_a         <= '0;
      add_b         <= '0;
      add_rmode     <= 3'd0;
      rsp_valid_q   <= 2'b00;
      rsp_result_q  <= '0;
      rsp_ovf_q     <= 1'b0;
      rsp_unf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
      sticky_ovf_q  <= 2'b00;
      sticky_unf_q  <= 2'b00;
      cnt0          <= '0;
      cnt1          <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The adder operand registers double as the operand latch, so the
          // adder inputs only move when a new operation is accepted.
          if (req_fire) begin
            add_a      <= sel_a;
            add_b      <= sel_b;
            add_rmode  <= (sel_rm > 3'd4) ? 3'd0 : sel_rm;
            op_illegal <= (sel_rm > 3'd4);
            op_g       <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q  <= op_illegal ? QNAN : add_result;
          rsp_ovf_q     <= ~op_illegal & add_overflow;
          rsp_unf_q     <= ~op_illegal & add_underflow;
          rsp_illegal_q <= op_illegal;
          rsp_valid_q   <= op_g ? 2'b10 : 2'b01;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 2'b00;
            if (!op_g && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
            if (op_g && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A flag raised by a response overrides a clear in the same cycle.
      sticky_ovf_q <= set_ovf | (sticky_ovf_q & ~req.sticky_clr);
      sticky_unf_q <= set_unf | (sticky_unf_q & ~req.sticky_clr);
    end
  end

  assign req.req_ready   = req_ready_c;
  assign req.rsp_valid   = rsp_valid_q;
  assign req.rsp_result  = rsp_result_q;
  assign req.rsp_ovf     = rsp_ovf_q;
  assign req.rsp_unf     = rsp_unf_q;
  assign req.rsp_illegal = rsp_illegal_q;
  assign req.sticky_ovf  = sticky_ovf_q;
  assign req.sticky_unf  = sticky_unf_q;
  assign req.op_cnt0     = cnt0;
  assign req.op_cnt1     = cnt1;
  assign dbg_state       = state;

endmodule

// File: doc/fp_add_sched.md
# fp_add_sched

Sequencing and arbitration controller that shares one combinational `fp_adder` between two requesters (port 0, port 1). It owns the adder operand inputs and registers them, captures the adder result one cycle later, and returns it to the granted requester over a valid/ready response channel. It also keeps sticky per-port overflow/underflow status. It sits between the FPU issue logic and the shared adder datapath.

## Interface

Parameters:
- `CNT_W`, default 16: width of the per-port completed-operation counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid[1:0]`  in  2  request valid, per port.
- `req_ready[1:0]`  out  2  request accepted this cycle, per port.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  32 each  IEEE-754 single operands per port.
- `req_rmode0`, `req_rmode1`  in  3 each  rounding mode per port: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- `add_a`, `add_b`  out  32 each  to adder `fp_a`/`fp_b`.
- `add_rmode`  out  3  to adder `r_mode`.
- `add_result`  in  32  adder `fp_result`.
- `add_overflow`, `add_underflow`  in  1 each  adder flags.
- `rsp_valid[1:0]`  out  2  response valid, per port.
- `rsp_ready[1:0]`  in  2  response consumed, per port.
- `rsp_result`  out  32  result, shared by both ports.
- `rsp_ovf`, `rsp_unf`, `rsp_illegal`  out  1 each  flags of the current response.
- `sticky_ovf[1:0]`, `sticky_unf[1:0]`  out  2 each  sticky per-port flags.
- `sticky_clr[1:0]`  in  2  clears the sticky flags of that port.
- `op_cnt0`, `op_cnt1`  out  CNT_W each  completed responses per port; saturating.

## Operation

- The FSM has three states: IDLE, EXEC, RESP. A single operation is outstanding at a time.
- IDLE:
  - The arbiter picks a grant `g`. With one port valid, that port wins. With both valid, the port other than `last_grant` wins (round-robin).
  - `req_ready[g]=1` only while in IDLE and `req_valid[g]=1`. The other `req_ready` bit is 0.
  - On handshake: latch `a`, `b`, `rmode` and `g` into operand registers, set `last_grant<=g`, go to EXEC.
- EXEC:
  - `add_a`, `add_b`, `add_rmode` are driven from the operand registers.
  - At the end of the cycle, capture `add_result`, `add_overflow`, `add_underflow` into the result registers, then go to RESP.
  - Illegal rmode (101–111): the adder sees `add_rmode=000`. The captured result is forced to 0x7FC00000 with `rsp_illegal=1`, `rsp_ovf=0`, `rsp_unf=0`.
- RESP:
  - `rsp_valid[g]=1` and is held with stable data until `rsp_ready[g]=1`.
  - On the response handshake:
    - set `sticky_ovf[g]` / `sticky_unf[g]` when the response flag is 1;
    - increment `op_cnt_g`, saturating at all-ones;
    - go to IDLE.
- Outside EXEC, `add_a`/`add_b`/`add_rmode` hold their last values. This avoids needless adder toggling.
- `sticky_clr[p]`:
  - clears both sticky bits of port p in the next cycle.
  - If a set and a clear of the same port happen in the same cycle, the set wins.

## Timing

- Reset values:
  - state IDLE, `last_grant=1` (so port 0 wins the first tie);
  - all `req_ready`, `rsp_valid`, sticky bits = 0;
  - `rsp_result`, `rsp_ovf`, `rsp_unf`, `rsp_illegal` = 0;
  - `add_a=add_b=0`, `add_rmode=000`;
  - `op_cnt0=op_cnt1=0`.
- Latency: request handshake at cycle t gives EXEC at t+1 and `rsp_valid` first high at t+2. Minimum issue interval is 3 cycles.
- `req_ready` is combinational from state, `req_valid` and `last_grant`. All other outputs are registered.
- A request is never accepted in the same cycle as a response handshake. A new grant is evaluated in the following IDLE cycle.
- A requester may drop `req_valid` before handshake. No state change results.
- Reset asserted mid-operation (EXEC or RESP) aborts it on the next edge:
  - no response is produced;
  - counters and sticky bits are cleared.
- Changes of `req_a*`/`req_b*` after handshake do not affect the in-flight result.

## Test plan

- Port 0 only, a=0x3F800000, b=0x3F800000, rmode=001:
  - `req_ready[0]` high in cycle 0;
  - `rsp_valid[0]` high at cycle 2, `rsp_result=0x40000000`, flags 0;
  - `op_cnt0=1` after the handshake.
- Port 1, a=0x000A0000, b=0x000A0000, rmode=001: `rsp_result=0x00140000`, `rsp_valid[1]` only.
- Both ports valid continuously from reset:
  - grants alternate 0,1,0,1;
  - each response carries its own port's operands (port 0: 0x01000000+0x00300000 RTZ gives 0x01180000).
- Port 0, a=b=0x7F7FFFFF, rmode=000:
  - `rsp_ovf=1`, `sticky_ovf[0]=1`, which persists after later clean ops;
  - `sticky_clr[0]` clears it next cycle;
  - a set coinciding with the clear leaves it 1.
- rmode=110 on port 1: `add_rmode=000` during EXEC, `rsp_result=0x7FC00000`, `rsp_illegal=1`.
- `rsp_ready[0]` held low for 5 cycles in RESP:
  - data is stable and no new request is accepted;
  - asserting `rst` in the 3rd cycle returns to IDLE with all outputs at reset values.
